// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit multiplexed 7-segment scanner.
// Segment patterns are active-high {g,f,e,d,c,b,a}.
package display_pkg;

  typedef enum logic [1:0] {
    UNITS_ON = 2'd0,
    BLANK_A  = 2'd1,
    TENS_ON  = 2'd2,
    BLANK_B  = 2'd3
  } state_t;

  localparam logic [6:0] SEG_PATTERNS [10] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [0:0] AN_UNITS = 1'b0;
  localparam logic [0:0] AN_TENS  = 1'b1;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-high 7-segment pattern.
// Non-decimal codes (10-15) light nothing.
module bcd_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup with a dark fallback for out-of-range codes
  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9) begin
      seg = SEG_PATTERNS[bcd];
    end else begin
      seg = SEG_BLANK;
    end
  end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed two-digit 7-segment driver with blanking between digits
// and value updates only at frame boundaries so a digit pair never tears.
module display_scanner
  import display_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES    = 13500,
  parameter int unsigned BLANK_CYCLES    = 64,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter bit          LEAD_ZERO_BLANK = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] binary_i,
  input  logic       load_i,
  output logic [6:0] seg_o,
  output logic [1:0] an_o,
  output logic       frame_o
);

  localparam int unsigned MAX_LEN = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  // XOR masks: polarity is folded in exactly once, at the output registers
  localparam logic [6:0] SEG_POL = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0] AN_POL  = ACTIVE_LOW ? 2'b11 : 2'b00;

  state_t           state_r, next_state_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic             phase_last_s;
  logic             boundary_s;

  logic [3:0]       pending_r;
  logic             pending_vld_r;
  logic [3:0]       shown_r;
  logic [3:0]       shown_next_s;

  logic             tens_s;
  logic [3:0]       units_s;
  logic [3:0]       tens_digit_s;
  logic [6:0]       units_pat_s;
  logic [6:0]       tens_pat_s;
  logic [6:0]       seg_hi_s;
  logic [1:0]       an_hi_s;

  // Phase sequencing: counter end detection and state advance
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = cnt_r + CNT_W'(1);
    phase_last_s = 1'b0;
    case (state_r)
      UNITS_ON, TENS_ON: phase_last_s = (cnt_r == DWELL_LAST);
      BLANK_A, BLANK_B:  phase_last_s = (cnt_r == BLANK_LAST);
      default:           phase_last_s = 1'b1;
    endcase
    if (phase_last_s) begin
      cnt_next_s = '0;
      case (state_r)
        UNITS_ON: next_state_s = BLANK_A;
        BLANK_A:  next_state_s = TENS_ON;
        TENS_ON:  next_state_s = BLANK_B;
        BLANK_B:  next_state_s = UNITS_ON;
        default:  next_state_s = BLANK_B;
      endcase
    end else begin
      next_state_s = state_r;
    end
    boundary_s = phase_last_s && (state_r == BLANK_B);
  end

  // State and phase counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= BLANK_B;
      cnt_r   <= '0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Outputs are decoded from the upcoming value so the new digit appears on the boundary edge
  always_comb begin
    shown_next_s = shown_r;
    if (boundary_s && pending_vld_r) begin
      shown_next_s = pending_r;
    end else begin
      shown_next_s = shown_r;
    end
    tens_s       = (shown_next_s >= 4'd10);
    units_s      = tens_s ? (shown_next_s - 4'd10) : shown_next_s;
    tens_digit_s = {3'b000, tens_s};
  end

  bcd_to_7seg u_units_dec (
    .bcd (units_s),
    .seg (units_pat_s)
  );

  bcd_to_7seg u_tens_dec (
    .bcd (tens_digit_s),
    .seg (tens_pat_s)
  );

  // Active-high anode and segment selection for the state being entered
  always_comb begin
    seg_hi_s = SEG_BLANK;
    an_hi_s  = 2'b00;
    case (next_state_s)
      UNITS_ON: begin
        an_hi_s[AN_UNITS] = 1'b1;
        seg_hi_s          = units_pat_s;
      end
      TENS_ON: begin
        if (tens_s || !LEAD_ZERO_BLANK) begin
          an_hi_s[AN_TENS] = 1'b1;
          seg_hi_s         = tens_pat_s;
        end else begin
          an_hi_s  = 2'b00;
          seg_hi_s = SEG_BLANK;
        end
      end
      default: begin
        an_hi_s  = 2'b00;
        seg_hi_s = SEG_BLANK;
      end
    endcase
  end

  // Value staging, frame-boundary commit and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r     <= 4'd0;
      pending_vld_r <= 1'b0;
      shown_r       <= 4'd0;
      seg_o         <= SEG_POL;
      an_o          <= AN_POL;
      frame_o       <= 1'b0;
    end else begin
      if (load_i) begin
        pending_r <= binary_i;
      end else begin
        pending_r <= pending_r;
      end
      // A load on the boundary edge itself waits for the following frame
      if (boundary_s) begin
        pending_vld_r <= load_i;
      end else if (load_i) begin
        pending_vld_r <= 1'b1;
      end else begin
        pending_vld_r <= pending_vld_r;
      end
      shown_r <= shown_next_s;
      seg_o   <= seg_hi_s ^ SEG_POL;
      an_o    <= an_hi_s ^ AN_POL;
      frame_o <= boundary_s;
    end
  end

endmodule
